// File: rtl/mux21_sweep_ctrl.sv
// Clocked self-checking sweep controller for a 2:1 mux: drives all 8 {s,d1,d0}
// vectors, samples y after a settle time and counts mismatches. Optional fail log: MUX21_SWEEP_FAILLOG_EN.
module mux21_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y,
  output logic             d0,
  output logic             d1,
  output logic             s,
  output logic [2:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [2:0]       first_fail
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       vec_r, vec_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [ERR_W-1:0] err_r, err_nxt_s;
  logic             busy_r, done_r, pass_r;
  logic             mismatch_s;
  logic             clr_log_s;

  // Golden 2:1 mux response for a vector packed as {s,d1,d0}.
  function automatic logic mux_expect(input logic [2:0] v);
    return v[2] ? v[1] : v[0];
  endfunction

  // Saturating increment so the count never wraps back to a passing value.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    if (c == {ERR_W{1'b1}}) begin
      return c;
    end else begin
      return c + ERR_W'(1);
    end
  endfunction

  // Next-state and datapath next values.
  always_comb begin
    state_nxt_s = state_r;
    vec_nxt_s   = vec_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = err_r;
    mismatch_s  = 1'b0;
    clr_log_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_nxt_s   = 3'd0;
          cnt_nxt_s   = {CNT_W{1'b0}};
          err_nxt_s   = {ERR_W{1'b0}};
          clr_log_s   = 1'b1;
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_nxt_s = ST_CHECK;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        // Expected value comes from the registered drive bits, i.e. vec_r.
        mismatch_s = (y != mux_expect(vec_r));
        if (mismatch_s) begin
          err_nxt_s = sat_inc(err_r);
        end else begin
          err_nxt_s = err_r;
        end
        if (vec_r == 3'd7) begin
          state_nxt_s = ST_DONE;
        end else begin
          vec_nxt_s   = vec_r + 3'd1;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_SETTLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      vec_r   <= 3'd0;
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= {ERR_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      vec_r   <= vec_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_CHECK);
      done_r  <= (state_nxt_s == ST_DONE);
      pass_r  <= (state_nxt_s == ST_DONE) && (err_nxt_s == {ERR_W{1'b0}});
    end
  end

`ifdef MUX21_SWEEP_FAILLOG_EN
  logic       fail_seen_r, fail_seen_nxt_s;
  logic [2:0] first_fail_r, first_fail_nxt_s;

  // First-mismatch capture; later mismatches leave the log untouched.
  always_comb begin
    fail_seen_nxt_s  = fail_seen_r;
    first_fail_nxt_s = first_fail_r;
    if (clr_log_s) begin
      fail_seen_nxt_s  = 1'b0;
      first_fail_nxt_s = 3'd0;
    end else if (mismatch_s && !fail_seen_r) begin
      fail_seen_nxt_s  = 1'b1;
      first_fail_nxt_s = vec_r;
    end else begin
      fail_seen_nxt_s  = fail_seen_r;
      first_fail_nxt_s = first_fail_r;
    end
  end

  // Fail log registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_seen_r  <= 1'b0;
      first_fail_r <= 3'd0;
    end else begin
      fail_seen_r  <= fail_seen_nxt_s;
      first_fail_r <= first_fail_nxt_s;
    end
  end

  assign fail_seen  = fail_seen_r;
  assign first_fail = first_fail_r;
`else
  logic unused_log_s;
  assign unused_log_s = clr_log_s;
  assign fail_seen    = 1'b0;
  assign first_fail   = 3'd0;
`endif

  assign d0      = vec_r[0];
  assign d1      = vec_r[1];
  assign s       = vec_r[2];
  assign vec_idx = vec_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign pass    = pass_r;
  assign err_cnt = err_r;

endmodule

// File: tb/tb_mux21_sweep_ctrl.sv
// Bench for mux21_sweep_ctrl: two instances (settle 1 and 3) driven by a behavioural
// faulty-mux model; expectations derived from a per-vector mismatch table.
module tb_mux21_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic y1, y3;
  logic d0_1, d1_1, s_1, busy1, done1, pass1, fs1;
  logic d0_3, d1_3, s_3, busy3, done3, pass3, fs3;
  logic [2:0] vec1, vec3, ff1, ff3;
  logic [3:0] err1, err3;

  int mode1 = 0, mode3 = 0;
  logic [7:0] tbl1 = 8'd0, tbl3 = 8'd0;
  int cur = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Mux under test: 0 ideal, 1 stuck-at-0, 2 inverted, 3 swapped inputs, 4 arbitrary truth table.
  function automatic logic model_y(input int mode, input logic [7:0] tbl, input logic [2:0] v);
    int i;
    int sb, b1, b0;
    i  = int'(v);
    sb = (i >> 2) & 1;
    b1 = (i >> 1) & 1;
    b0 = i & 1;
    case (mode)
      0: return logic'(sb != 0 ? b1 : b0);
      1: return 1'b0;
      2: return logic'(sb != 0 ? 1 - b1 : 1 - b0);
      3: return logic'(sb != 0 ? b0 : b1);
      4: return tbl[i];
      default: return 1'b0;
    endcase
  endfunction

  assign y1 = model_y(mode1, tbl1, {s_1, d1_1, d0_1});
  assign y3 = model_y(mode3, tbl3, {s_3, d1_3, d0_3});

  mux21_sweep_ctrl #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y(y1), .d0(d0_1), .d1(d1_1), .s(s_1),
    .vec_idx(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_seen(fs1), .first_fail(ff1));

  mux21_sweep_ctrl #(.SETTLE_CYCLES(3), .ERR_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .y(y3), .d0(d0_3), .d1(d1_3), .s(s_3),
    .vec_idx(vec3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_seen(fs3), .first_fail(ff3));

  logic       busy_m, done_m, pass_m, fs_m;
  logic [2:0] vec_m, drv_m, ff_m;
  logic [3:0] err_m;
  assign busy_m = (cur != 0) ? busy3 : busy1;
  assign done_m = (cur != 0) ? done3 : done1;
  assign pass_m = (cur != 0) ? pass3 : pass1;
  assign fs_m   = (cur != 0) ? fs3 : fs1;
  assign vec_m  = (cur != 0) ? vec3 : vec1;
  assign ff_m   = (cur != 0) ? ff3 : ff1;
  assign err_m  = (cur != 0) ? err3 : err1;
  assign drv_m  = (cur != 0) ? {s_3, d1_3, d0_3} : {s_1, d1_1, d0_1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start3 = v;
    else start1 = v;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vec"}, 32'(vec_m), 32'd0);
    chk({tag, "_drv"}, 32'(drv_m), 32'd0);
    chk({tag, "_busy"}, 32'(busy_m), 32'd0);
    chk({tag, "_done"}, 32'(done_m), 32'd0);
    chk({tag, "_pass"}, 32'(pass_m), 32'd0);
    chk({tag, "_err"}, 32'(err_m), 32'd0);
    chk({tag, "_fs"}, 32'(fs_m), 32'd0);
    chk({tag, "_ff"}, 32'(ff_m), 32'd0);
  endtask

  // One full sweep on the selected instance with a given fault model.
  task automatic run_sweep(input int sel, input int mode, input logic [7:0] tbl, input bit repulse);
    int settle, n, nmis, first;
    logic exp_fs;
    logic [2:0] exp_ff;
    cur    = sel;
    settle = (sel != 0) ? 3 : 1;
    if (sel != 0) begin mode3 = mode; tbl3 = tbl; end
    else begin mode1 = mode; tbl1 = tbl; end
    nmis  = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (model_y(mode, tbl, 3'(i)) != model_y(0, 8'd0, 3'(i))) begin
        nmis++;
        if (first < 0) first = i;
      end
    end
    @(posedge clk); #1 set_start(sel, 1'b1);
    @(posedge clk); #1 set_start(sel, 1'b0);
    chk("start_busy", 32'(busy_m), 32'd1);
    chk("start_done", 32'(done_m), 32'd0);
    chk("start_err_clr", 32'(err_m), 32'd0);
    chk("start_vec", 32'(vec_m), 32'd0);
    chk("start_fs_clr", 32'(fs_m), 32'd0);
    n = 0;
    while (!done_m && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (repulse && n == 5) set_start(sel, 1'b1);
      if (repulse && n == 6) set_start(sel, 1'b0);
      chk("drv_eq_vec", 32'(drv_m), 32'(vec_m));
      chk("busy_done_excl", 32'(busy_m & done_m), 32'd0);
    end
    chk("latency", 32'(n), 32'(8 * (settle + 1)));
    chk("err_cnt", 32'(err_m), 32'(nmis > 15 ? 15 : nmis));
    chk("pass", 32'(pass_m), 32'(nmis == 0));
    chk("busy_end", 32'(busy_m), 32'd0);
`ifdef MUX21_SWEEP_FAILLOG_EN
    exp_fs = (nmis != 0);
    exp_ff = (first < 0) ? 3'd0 : 3'(first);
`else
    exp_fs = 1'b0;
    exp_ff = 3'd0;
`endif
    chk("fail_seen", 32'(fs_m), 32'(exp_fs));
    chk("first_fail", 32'(ff_m), 32'(exp_ff));
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", 32'(done_m), 32'd1);
    chk("err_hold", 32'(err_m), 32'(nmis > 15 ? 15 : nmis));
  endtask

  initial begin
    int n;
    // Reset with start asserted: reset must win.
    rst = 1'b1; start1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cur = 0; check_zero("rst1");
    cur = 1; check_zero("rst3");
    rst = 1'b0; start1 = 1'b0;

    run_sweep(0, 0, 8'd0, 1'b0);
    run_sweep(0, 1, 8'd0, 1'b0);
    run_sweep(0, 2, 8'd0, 1'b0);
    run_sweep(0, 3, 8'd0, 1'b0);
    run_sweep(0, 0, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) run_sweep(0, 4, 8'($urandom_range(255, 0)), 1'b0);

    run_sweep(1, 0, 8'd0, 1'b1);
    run_sweep(1, 3, 8'd0, 1'b1);
    run_sweep(1, 2, 8'd0, 1'b0);
    for (int k = 0; k < 2; k++) run_sweep(1, 4, 8'($urandom_range(255, 0)), 1'b0);

    // Abort a sweep at vector 4 with reset, then re-run a full sweep.
    cur = 0; mode1 = 1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n = 0;
    while (vec1 != 3'd4 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("reach_vec4", 32'(vec1), 32'd4);
    chk("mid_err_nonzero", 32'(err1 != 4'd0), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_zero("abort");
    run_sweep(0, 0, 8'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
